// File: rtl/hes_pkg.sv
// hes_pkg: shared definitions for the HES stream decipher.
//   hes_state_e - message FSM state (idle until the first new_message beat)
//   SBOX        - AES forward S-box, indexed by (key_reg ^ ctr)
package hes_pkg;

    typedef enum logic {
        StIdle   = 1'b0,
        StActive = 1'b1
    } hes_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/hes_byte_fifo.sv
// hes_byte_fifo: first-word-fall-through FIFO used as the decipher output buffer.
// Ports:
//   clk, reset_n        - clock; asynchronous reset, active-high (empties the FIFO)
//   i_push, i_data      - write request and data
//   i_pop               - read request (head advances when not empty)
//   o_data              - current head; zero while empty
//   o_full, o_empty     - occupancy flags
//   o_count             - number of stored entries (0..DEPTH)
// A push on a full FIFO is accepted only together with a pop (occupancy unchanged).
module hes_byte_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_en;
    logic             w_pop_en;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_pop_en  = i_pop && !o_empty;
    assign w_push_en = i_push && (!o_full || w_pop_en);
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_en) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push_en, w_pop_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/hes_stream_decipher.sv
// hes_stream_decipher: byte-stream decipher, plaintext = data_in ^ SBOX[key_reg ^ ctr].
// Ports:
//   clk, reset_n             - clock; asynchronous reset, active-high
//   valid_in, ready_out      - ciphertext handshake (beat accepted when both high)
//   new_message, key         - first-byte qualifier and its key (sampled on that beat)
//   data_in                  - ciphertext byte
//   data_out, valid_out      - plaintext FWFT output, popped when ready_in is high
//   ready_in                 - downstream ready
//   err                      - sticky: continuation byte seen before any message start
// Pipeline: accept -> stage 1 (byte + sbox index) -> stage 2 (plaintext) -> FIFO,
// so a byte accepted at edge N reaches an empty FIFO's head after edge N+2.
module hes_stream_decipher
    import hes_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       valid_in,
    output logic       ready_out,
    input  logic       new_message,
    input  logic [7:0] key,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    input  logic       ready_in,
    output logic       err
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    hes_state_e r_state;
    hes_state_e w_state_next;
    logic [7:0] r_ctr;
    logic [7:0] w_ctr_next;
    logic [7:0] r_key;
    logic [7:0] w_key_next;
    logic       r_err;
    logic       w_err_next;
    logic       r_live;

    logic       r_s1_valid;
    logic [7:0] r_s1_data;
    logic [7:0] r_s1_idx;
    logic       w_s1_load;
    logic [7:0] w_s1_idx;

    logic       r_s2_valid;
    logic [7:0] r_s2_data;

    logic       w_accept;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic [CW:0]   w_occupancy;

    // Every byte already committed (in a stage or buffered) is counted, so the
    // stage-2 push always finds room and nothing is dropped.
    assign w_occupancy = {1'b0, w_fifo_count} + (CW+1)'(r_s1_valid) + (CW+1)'(r_s2_valid);
    assign ready_out   = r_live && (w_occupancy < (CW+1)'(FIFO_DEPTH));
    assign w_accept    = valid_in && ready_out;
    assign valid_out   = !w_fifo_empty;
    assign err         = r_err;

    always_comb begin
        w_state_next = r_state;
        w_ctr_next   = r_ctr;
        w_key_next   = r_key;
        w_err_next   = r_err;
        w_s1_load    = 1'b0;
        w_s1_idx     = r_key ^ r_ctr;
        if (w_accept) begin
            if (new_message) begin
                w_key_next   = key;
                w_s1_idx     = key;        // ctr is 0 for the first byte
                w_ctr_next   = 8'h01;
                w_s1_load    = 1'b1;
                w_state_next = StActive;
            end else if (r_state == StActive) begin
                w_ctr_next   = r_ctr + 8'h01;
                w_s1_load    = 1'b1;
            end else begin
                w_err_next   = 1'b1;       // orphan byte: dropped
            end
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_state <= StIdle;
            r_ctr   <= 8'h00;
            r_key   <= 8'h00;
            r_err   <= 1'b0;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ctr   <= w_ctr_next;
            r_key   <= w_key_next;
            r_err   <= w_err_next;
            r_live  <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= 8'h00;
            r_s1_idx   <= 8'h00;
            r_s2_valid <= 1'b0;
            r_s2_data  <= 8'h00;
        end else begin
            r_s1_valid <= w_s1_load;
            if (w_s1_load) begin
                r_s1_data <= data_in;
                r_s1_idx  <= w_s1_idx;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= r_s1_data ^ SBOX[r_s1_idx];
            end
        end
    end

    hes_byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (r_s2_valid),
        .i_data  (r_s2_data),
        .i_pop   (ready_in),
        .o_data  (data_out),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

endmodule

// File: tb/tb_hes_stream_decipher.sv
module tb_hes_stream_decipher;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       valid_in;
    logic       ready_out;
    logic       new_message;
    logic [7:0] key;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_in;
    logic       err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [7:0] out_q [$];

    typedef struct {
        logic       nm;
        logic [7:0] k;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    hes_stream_decipher #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .new_message (new_message),
        .key         (key),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bytes popped at the next rising edge.
    always @(negedge clk) begin
        if (reset_n == 1'b0 && valid_out && ready_in) out_q.push_back(data_out);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic beat(input logic nm, input logic [7:0] k, input logic [7:0] d);
        bit ok;
        ok          = 1'b0;
        valid_in    = 1'b1;
        new_message = nm;
        key         = k;
        data_in     = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = ready_out;
            @(posedge clk);
            #1;
        end
        valid_in    = 1'b0;
        new_message = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    // Assert reset just after an edge, release it on the following falling edge.
    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        tick(1);
        out_q.delete();
    endtask

    initial begin
        vec_t vecs [9];
        int   idx;
        int   c0;
        bit   acc;
        logic [7:0] bp_exp [6];

        vecs[0] = '{1'b1, 8'h00, 8'h63, 8'h00};
        vecs[1] = '{1'b0, 8'h00, 8'h7c, 8'h00};
        vecs[2] = '{1'b1, 8'h01, 8'h7d, 8'h01};
        vecs[3] = '{1'b0, 8'h00, 8'h77, 8'h14};
        vecs[4] = '{1'b0, 8'h00, 8'h00, 8'h7b};
        vecs[5] = '{1'b1, 8'hff, 8'h00, 8'h16};
        vecs[6] = '{1'b0, 8'h00, 8'hff, 8'h44};
        vecs[7] = '{1'b1, 8'h10, 8'hca, 8'h00};
        vecs[8] = '{1'b0, 8'h00, 8'h00, 8'h82};
        bp_exp  = '{8'h63, 8'h7d, 8'h75, 8'h78, 8'hf6, 8'h6e};

        reset_n     = 1'b1;
        valid_in    = 1'b0;
        new_message = 1'b0;
        key         = 8'h00;
        data_in     = 8'h00;
        ready_in    = 1'b1;

        // Reset state and first-edge ready.
        #1;
        check("rst_valid_out", int'(valid_out), 0);
        check("rst_data_out", int'(data_out), 0);
        check("rst_ready_out", int'(ready_out), 0);
        check("rst_err", int'(err), 0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("ready_before_edge", int'(ready_out), 0);
        tick(1);
        check("ready_after_edge", int'(ready_out), 1);

        // Two-edge latency from an empty FIFO.
        out_q.delete();
        beat(1'b1, 8'h00, 8'h63);
        check("lat_edge_n", int'(valid_out), 0);
        tick(1);
        check("lat_edge_n1", int'(valid_out), 0);
        tick(1);
        check("lat_edge_n2_valid", int'(valid_out), 1);
        check("lat_edge_n2_data", int'(data_out), 8'h00);
        beat(1'b0, 8'h00, 8'h7c);
        tick(5);
        check("lat_count", out_q.size(), 2);
        if (out_q.size() == 2) check("lat_second", int'(out_q[1]), 8'h00);

        // Table of directed beats streamed back to back.
        pulse_reset();
        foreach (vecs[i]) beat(vecs[i].nm, vecs[i].k, vecs[i].din);
        tick(6);
        check("vec_count", out_q.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < out_q.size()) check($sformatf("vec%0d", i), int'(out_q[i]), int'(vecs[i].exp));
        end

        // 257 beats of 0x63: ctr wraps and full throughput.
        pulse_reset();
        c0 = cyc;
        for (int k = 0; k < 257; k++) beat(k == 0, 8'h00, 8'h63);
        check("wrap_cycles", cyc - c0, 257);
        tick(6);
        check("wrap_count", out_q.size(), 257);
        if (out_q.size() == 257) begin
            check("wrap_b1", int'(out_q[0]), 8'h00);
            check("wrap_b2", int'(out_q[1]), 8'h1f);
            check("wrap_b256", int'(out_q[255]), 8'h75);
            check("wrap_b257", int'(out_q[256]), 8'h00);
        end

        // Backpressure: six beats offered with ready_in low.
        pulse_reset();
        ready_in = 1'b0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            valid_in    = (idx < 6);
            new_message = (idx == 0);
            key         = 8'h00;
            data_in     = 8'(idx);
            @(negedge clk);
            acc = ready_out && valid_in;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        check("bp_accepted", idx, 4);
        check("bp_ready_low", int'(ready_out), 0);
        check("bp_valid", int'(valid_out), 1);
        check("bp_head", int'(data_out), 8'h63);
        tick(2);
        check("bp_head_stable", int'(data_out), 8'h63);
        check("bp_none_popped", out_q.size(), 0);
        ready_in = 1'b1;
        for (int c = 0; c < 30 && idx < 6; c++) begin
            valid_in    = 1'b1;
            new_message = 1'b0;
            data_in     = 8'(idx);
            @(negedge clk);
            acc = ready_out;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        valid_in = 1'b0;
        tick(8);
        check("bp_total", out_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < out_q.size()) check($sformatf("bp%0d", i), int'(out_q[i]), int'(bp_exp[i]));
        end

        // Continuation byte from IDLE: dropped, sticky err.
        pulse_reset();
        beat(1'b0, 8'h00, 8'h63);
        tick(4);
        check("orphan_err", int'(err), 1);
        check("orphan_no_valid", int'(valid_out), 0);
        check("orphan_no_output", out_q.size(), 0);
        beat(1'b1, 8'h00, 8'h63);
        tick(4);
        check("err_sticky", int'(err), 1);
        check("after_orphan_out", out_q.size(), 1);

        // Reset mid-message with three bytes buffered.
        ready_in = 1'b0;
        beat(1'b1, 8'h00, 8'h63);
        beat(1'b0, 8'h00, 8'h7c);
        beat(1'b0, 8'h00, 8'h77);
        tick(3);
        check("mid_buffered", int'(valid_out), 1);
        check("mid_err_before", int'(err), 1);
        reset_n = 1'b1;
        #1;
        check("mid_rst_valid", int'(valid_out), 0);
        check("mid_rst_err", int'(err), 0);
        check("mid_rst_ready", int'(ready_out), 0);
        check("mid_rst_data", int'(data_out), 0);
        @(negedge clk);
        reset_n  = 1'b0;
        ready_in = 1'b1;
        tick(1);
        out_q.delete();
        beat(1'b1, 8'h00, 8'h63);
        tick(5);
        check("post_rst_count", out_q.size(), 1);
        if (out_q.size() == 1) check("post_rst_data", int'(out_q[0]), 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
